// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the ALU command sequencer and its environment:
// command handshake, ALU input/output bus and response handshake.
// With ALU_SEQ_CHAIN_EN defined the bundle also carries cmd_chain.
interface alu_cmd_sequencer_if;
`ifdef ALU_SEQ_CHAIN_EN
    logic       cmd_chain;
`endif
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_op1;
    logic [3:0] alu_op2;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_cout;
    logic       rsp_zero;
    logic       rsp_err;

    // Sequencer view.
    modport master (
`ifdef ALU_SEQ_CHAIN_EN
        input  cmd_chain,
`endif
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_op1, alu_op2, alu_ctrl,
        input  alu_out, alu_cout,
        output rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err,
        input  rsp_ready
    );

    // Environment view: command source, ALU and response consumer.
    modport slave (
`ifdef ALU_SEQ_CHAIN_EN
        output cmd_chain,
`endif
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_op1, alu_op2, alu_ctrl,
        output alu_out, alu_cout,
        input  rsp_valid, rsp_data, rsp_cout, rsp_zero, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational 4-bit ALU: accepts a command, holds the operands
// on the ALU bus for SETTLE_CYCLES edges, captures the result with flags
// and hands it back over a valid/ready response channel.
// Optional macro ALU_SEQ_CHAIN_EN: adds cmd_chain and a result accumulator
// that can replace operand 1 of the next command.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_sequencer_if.master bus,
    output logic [CNT_W-1:0] cmd_count
);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       op1_reg, op1_next;
    logic [3:0]       op2_reg, op2_next;
    logic [2:0]       ctrl_reg, ctrl_next;
    logic [3:0]       settle_reg, settle_next;
    logic             valid_reg, valid_next;
    logic [3:0]       data_reg, data_next;
    logic             cout_reg, cout_next;
    logic             zero_reg, zero_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] count_reg, count_next;
`ifdef ALU_SEQ_CHAIN_EN
    logic [3:0]       acc_reg, acc_next;
`endif

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op1_reg    <= '0;
            op2_reg    <= '0;
            ctrl_reg   <= '0;
            settle_reg <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
            count_reg  <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            acc_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            op1_reg    <= op1_next;
            op2_reg    <= op2_next;
            ctrl_reg   <= ctrl_next;
            settle_reg <= settle_next;
            valid_reg  <= valid_next;
            data_reg   <= data_next;
            cout_reg   <= cout_next;
            zero_reg   <= zero_next;
            err_reg    <= err_next;
            count_reg  <= count_next;
`ifdef ALU_SEQ_CHAIN_EN
            acc_reg    <= acc_next;
`endif
        end
    end

    // Next-state logic: accept, settle countdown, capture, response handshake.
    always_comb begin
        state_next  = state_reg;
        op1_next    = op1_reg;
        op2_next    = op2_reg;
        ctrl_next   = ctrl_reg;
        settle_next = settle_reg;
        valid_next  = valid_reg;
        data_next   = data_reg;
        cout_next   = cout_reg;
        zero_next   = zero_reg;
        err_next    = err_reg;
        count_next  = count_reg;
`ifdef ALU_SEQ_CHAIN_EN
        acc_next    = acc_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op[2:1] == 2'b11) begin
                        // Illegal opcode: answer immediately, leave the ALU bus alone.
                        data_next  = 4'd0;
                        cout_next  = 1'b0;
                        zero_next  = 1'b1;
                        err_next   = 1'b1;
                        valid_next = 1'b1;
                        state_next = RESP;
                    end else begin
`ifdef ALU_SEQ_CHAIN_EN
                        op1_next = bus.cmd_chain ? acc_reg : bus.cmd_a;
`else
                        op1_next = bus.cmd_a;
`endif
                        op2_next    = bus.cmd_b;
                        ctrl_next   = bus.cmd_op;
                        settle_next = SETTLE_INIT;
                        state_next  = DRIVE;
                    end
                end
            end
            DRIVE: begin
                settle_next = settle_reg - 4'd1;
                if (settle_reg == 4'd1) begin
                    // Carry only has meaning for ADD/SUB (ctrl[2] set).
                    data_next  = bus.alu_out;
                    cout_next  = ctrl_reg[2] & bus.alu_cout;
                    zero_next  = (bus.alu_out == 4'd0);
                    err_next   = 1'b0;
                    valid_next = 1'b1;
                    state_next = RESP;
`ifdef ALU_SEQ_CHAIN_EN
                    acc_next   = bus.alu_out;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    valid_next = 1'b0;
                    count_next = count_reg + CNT_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.alu_op1   = op1_reg;
    assign bus.alu_op2   = op2_reg;
    assign bus.alu_ctrl  = ctrl_reg;
    assign bus.rsp_valid = valid_reg;
    assign bus.rsp_data  = data_reg;
    assign bus.rsp_cout  = cout_reg;
    assign bus.rsp_zero  = zero_reg;
    assign bus.rsp_err   = err_reg;
    assign cmd_count     = count_reg;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: lane 0 uses SETTLE_CYCLES=1/CNT_W=8, lane 1
// uses SETTLE_CYCLES=4/CNT_W=3 (mid-DRIVE reset and counter wrap).
// A transaction-level model predicts every output each cycle; directed
// sends also check hand-computed literal results.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, rst_n1;
    logic [7:0] cnt0;
    logic [2:0] cnt1;
    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer_if bus0();
    alu_cmd_sequencer_if bus1();

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(bus0), .cmd_count(cnt0));
    alu_cmd_sequencer #(.SETTLE_CYCLES(4), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(bus1), .cmd_count(cnt1));

`ifdef ALU_SEQ_CHAIN_EN
    assign bus0.cmd_chain = 1'b0;
    assign bus1.cmd_chain = 1'b0;
`endif

    // Stand-in for alu_4bit. Logical ops return cout=1 so masking is visible.
    function automatic logic [4:0] alu_fn(input logic [3:0] x, input logic [3:0] y,
                                          input logic [2:0] c);
        case (c)
            3'd0:    return {1'b1, x & y};
            3'd1:    return {1'b1, x | y};
            3'd2:    return {1'b1, ~x};
            3'd3:    return {1'b1, x ^ y};
            3'd4:    return {1'b0, x} + {1'b0, y};
            3'd5:    return {1'b0, x} + {1'b0, ~y} + 5'd1;
            default: return 5'd0;
        endcase
    endfunction
    assign {bus0.alu_cout, bus0.alu_out} = alu_fn(bus0.alu_op1, bus0.alu_op2, bus0.alu_ctrl);
    assign {bus1.alu_cout, bus1.alu_out} = alu_fn(bus1.alu_op1, bus1.alu_op2, bus1.alu_ctrl);

    function automatic int settle_of(input int l); return (l == 0) ? 1 : 4; endfunction
    function automatic int mod_of(input int l);    return (l == 0) ? 256 : 8; endfunction

    // Expected {cout, result} from plain integer arithmetic.
    function automatic logic [4:0] ref_result(input int op, input int a, input int b);
        int r; bit c;
        c = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = 15 - a;
            3: r = a ^ b;
            4: begin r = (a + b) % 16; c = (a + b) > 15; end
            default: begin r = (a - b + 16) % 16; c = (a >= b); end
        endcase
        return {c, 4'(r)};
    endfunction

    // ---------------- transaction model ----------------
    bit         m_busy[2], m_rv[2], m_cout[2], m_zero[2], m_err[2], m_pcout[2];
    int         m_wait[2], m_count[2];
    logic [3:0] m_op1[2], m_op2[2], m_data[2], m_pdata[2];
    logic [2:0] m_ctrl[2];

    task automatic model_reset(input int l);
        m_busy[l] = 0; m_rv[l] = 0; m_cout[l] = 0; m_zero[l] = 0; m_err[l] = 0;
        m_wait[l] = 0; m_count[l] = 0; m_op1[l] = 0; m_op2[l] = 0; m_ctrl[l] = 0;
        m_data[l] = 0; m_pdata[l] = 0; m_pcout[l] = 0;
    endtask

    task automatic model_step(input int l, input logic v, input logic [2:0] op,
                              input logic [3:0] a, input logic [3:0] b, input logic rr);
        if (!m_busy[l]) begin
            if (v) begin
                m_busy[l] = 1;
                if (op >= 3'd6) begin
                    m_rv[l] = 1; m_data[l] = 0; m_cout[l] = 0; m_zero[l] = 1; m_err[l] = 1;
                end else begin
                    m_op1[l] = a; m_op2[l] = b; m_ctrl[l] = op;
                    m_wait[l] = settle_of(l);
                    {m_pcout[l], m_pdata[l]} = ref_result(int'(op), int'(a), int'(b));
                end
            end
        end else if (m_rv[l]) begin
            if (rr) begin
                m_rv[l] = 0; m_busy[l] = 0;
                m_count[l] = (m_count[l] + 1) % mod_of(l);
            end
        end else begin
            m_wait[l]--;
            if (m_wait[l] == 0) begin
                m_rv[l] = 1; m_data[l] = m_pdata[l]; m_cout[l] = m_pcout[l];
                m_zero[l] = (m_pdata[l] == 4'd0); m_err[l] = 0;
            end
        end
    endtask

    // Advance lane-0 model on each edge or reset.
    always @(posedge clk or negedge rst_n0)
        if (!rst_n0) model_reset(0);
        else model_step(0, bus0.cmd_valid, bus0.cmd_op, bus0.cmd_a, bus0.cmd_b, bus0.rsp_ready);

    // Advance lane-1 model on each edge or reset.
    always @(posedge clk or negedge rst_n1)
        if (!rst_n1) model_reset(1);
        else model_step(1, bus1.cmd_valid, bus1.cmd_op, bus1.cmd_a, bus1.cmd_b, bus1.rsp_ready);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_lane(input int l, input logic rdy, input logic [3:0] o1,
                              input logic [3:0] o2, input logic [2:0] ct, input logic rv,
                              input logic [3:0] d, input logic c, input logic z,
                              input logic e, input int cnt);
        string p;
        p = $sformatf("L%0d ", l);
        chk({p, "cmd_ready"}, int'(rdy), int'(!m_busy[l]));
        chk({p, "alu_op1"},   int'(o1), int'(m_op1[l]));
        chk({p, "alu_op2"},   int'(o2), int'(m_op2[l]));
        chk({p, "alu_ctrl"},  int'(ct), int'(m_ctrl[l]));
        chk({p, "rsp_valid"}, int'(rv), int'(m_rv[l]));
        chk({p, "rsp_data"},  int'(d),  int'(m_data[l]));
        chk({p, "rsp_cout"},  int'(c),  int'(m_cout[l]));
        chk({p, "rsp_zero"},  int'(z),  int'(m_zero[l]));
        chk({p, "rsp_err"},   int'(e),  int'(m_err[l]));
        chk({p, "cmd_count"}, cnt, m_count[l]);
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        check_lane(0, bus0.cmd_ready, bus0.alu_op1, bus0.alu_op2, bus0.alu_ctrl, bus0.rsp_valid,
                   bus0.rsp_data, bus0.rsp_cout, bus0.rsp_zero, bus0.rsp_err, int'(cnt0));
        check_lane(1, bus1.cmd_ready, bus1.alu_op1, bus1.alu_op2, bus1.alu_ctrl, bus1.rsp_valid,
                   bus1.rsp_data, bus1.rsp_cout, bus1.rsp_zero, bus1.rsp_err, int'(cnt1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int l, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        if (l == 0) begin bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_a = a; bus0.cmd_b = b; end
        else        begin bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b; end
    endtask
    task automatic set_rready(input int l, input logic r);
        if (l == 0) bus0.rsp_ready = r; else bus1.rsp_ready = r;
    endtask
    function automatic logic get_ready(input int l);
        return (l == 0) ? bus0.cmd_ready : bus1.cmd_ready;
    endfunction
    function automatic logic get_rv(input int l);
        return (l == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic [6:0] get_rsp(input int l);
        return (l == 0) ? {bus0.rsp_data, bus0.rsp_cout, bus0.rsp_zero, bus0.rsp_err}
                        : {bus1.rsp_data, bus1.rsp_cout, bus1.rsp_zero, bus1.rsp_err};
    endfunction
    function automatic int get_cnt(input int l);
        return (l == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // One full command/response transaction with literal expectations.
    task automatic send(input int l, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int stall, input logic [3:0] ed,
                        input logic ec, input logic ez, input logic ee);
        int n;
        int lat;
        logic [6:0] r;
        @(posedge clk); #1;
        set_rready(l, stall == 0);
        drive(l, 1'b1, op, a, b);
        n = 0;
        @(negedge clk);
        while (!get_ready(l) && n < 20) begin n++; @(negedge clk); end
        chk("accept wait", int'(get_ready(l)), 1);
        @(posedge clk); #1;
        drive(l, 1'b0, 3'd0, 4'd0, 4'd0);
        n = 0;
        @(negedge clk);
        while (!get_rv(l) && n < 40) begin n++; @(negedge clk); end
        lat = (op >= 3'd6) ? 0 : settle_of(l);
        chk("latency", n, lat);
        r = get_rsp(l);
        $display("lane%0d op=%0d a=%0d b=%0d -> data=%0d cout=%0d zero=%0d err=%0d",
                 l, op, a, b, r[6:3], r[2], r[1], r[0]);
        chk("rsp_data lit", int'(r[6:3]), int'(ed));
        chk("rsp_cout lit", int'(r[2]), int'(ec));
        chk("rsp_zero lit", int'(r[1]), int'(ez));
        chk("rsp_err lit",  int'(r[0]), int'(ee));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall cmd_ready", int'(get_ready(l)), 0);
                chk("stall rsp_valid", int'(get_rv(l)), 1);
                chk("stall rsp hold", int'(get_rsp(l)), int'(r));
            end
            @(posedge clk); #1;
            set_rready(l, 1'b1);
            @(negedge clk);
        end
        @(negedge clk);
        chk("ready after rsp", int'(get_ready(l)), 1);
        chk("rsp_valid drop", int'(get_rv(l)), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        drive(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive(1, 1'b0, 3'd0, 4'd0, 4'd0);
        set_rready(0, 1'b1); set_rready(1, 1'b1);
        #12;
        chk("reset cmd_ready", int'(bus0.cmd_ready), 1);
        chk("reset alu_ctrl", int'(bus0.alu_ctrl), 0);
        chk("reset rsp_valid", int'(bus0.rsp_valid), 0);
        chk("reset count", int'(cnt0), 0);
        #10;
        rst_n0 = 1'b1; rst_n1 = 1'b1;

        // Lane 0, SETTLE_CYCLES=1.
        send(0, 3'b100, 4'b1001, 4'b0101, 0, 4'b1110, 0, 0, 0);
        chk("count after ADD", get_cnt(0), 1);
        send(0, 3'b101, 4'b0001, 4'b0100, 0, 4'b1101, 0, 0, 0);
        send(0, 3'b101, 4'b0101, 4'b0101, 0, 4'b0000, 1, 1, 0);
        send(0, 3'b000, 4'b1000, 4'b1011, 0, 4'b1000, 0, 0, 0);
        send(0, 3'b010, 4'b1011, 4'b0000, 0, 4'b0100, 0, 0, 0);
        send(0, 3'b011, 4'b1001, 4'b1100, 0, 4'b0101, 0, 0, 0);
        send(0, 3'b110, 4'b1111, 4'b1111, 0, 4'b0000, 0, 1, 1);
        chk("illegal alu_ctrl held", int'(bus0.alu_ctrl), 3);
        chk("illegal alu_op1 held", int'(bus0.alu_op1), 9);
        send(0, 3'b111, 4'b0001, 4'b0001, 0, 4'b0000, 0, 1, 1);
        send(0, 3'b001, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0);
        send(0, 3'b100, 4'b1111, 4'b0001, 0, 4'b0000, 1, 1, 0);
        c0 = get_cnt(0);
        send(0, 3'b100, 4'b0111, 4'b1000, 5, 4'b1111, 0, 0, 0);
        chk("count after stall", get_cnt(0), c0 + 1);

        // Lane 1, SETTLE_CYCLES=4.
        send(1, 3'b100, 4'b1001, 4'b1001, 0, 4'b0010, 1, 0, 0);
        send(1, 3'b110, 4'b0011, 4'b0011, 0, 4'b0000, 0, 1, 1);
        send(1, 3'b101, 4'b1000, 4'b0011, 3, 4'b0101, 1, 0, 0);
        chk("lane1 count", get_cnt(1), 3);

        // Reset in the second DRIVE cycle discards the pending response.
        @(posedge clk); #1;
        drive(1, 1'b1, 3'b100, 4'b0011, 4'b0010);
        @(posedge clk); #1;
        drive(1, 1'b0, 3'd0, 4'd0, 4'd0);
        @(posedge clk); #2;
        rst_n1 = 1'b0;
        #1;
        chk("midrst cmd_ready", int'(bus1.cmd_ready), 1);
        chk("midrst alu_op1", int'(bus1.alu_op1), 0);
        chk("midrst alu_op2", int'(bus1.alu_op2), 0);
        chk("midrst alu_ctrl", int'(bus1.alu_ctrl), 0);
        chk("midrst rsp_valid", int'(bus1.rsp_valid), 0);
        chk("midrst rsp_err", int'(bus1.rsp_err), 0);
        chk("midrst count", int'(cnt1), 0);
        @(posedge clk); #2;
        rst_n1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no rsp after rst", int'(bus1.rsp_valid), 0);
        end
        chk("count after rst", get_cnt(1), 0);

        // Nine completions on a 3-bit counter wrap to 1.
        for (int i = 0; i < 9; i++) begin
            logic [3:0] av;
            av = 4'(i);
            send(1, 3'b001, av, 4'b0001, 0, av | 4'b0001, 0, 0, 0);
        end
        chk("count wrap", get_cnt(1), 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
